// File: rtl/serial_pkg.sv
// Shared types and default constants for the serial link blocks (scheduler, SerialTx/SerialRx wrappers).
package serial_pkg;

    localparam int DEF_NREQ         = 4;
    localparam int DEF_DW           = 8;
    localparam int DEF_FRAME_CYCLES = 20;
    localparam int DEF_GAP_CYCLES   = 2;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_SEND,
        ST_FRAME,
        ST_GAP
    } sched_state_t;

endpackage

// File: rtl/serial_tx_sched_if.sv
// Requester-side bus of serial_tx_sched: request/data in, grant/owner/busy plus transmitter drive out.
interface serial_tx_sched_if
    import serial_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic [IW-1:0]      owner;
    logic               busy;
    logic               send;
    logic [DW-1:0]      pdOut;

    modport master (
        output req, data,
        input  gnt, owner, busy, send, pdOut
    );

    modport slave (
        input  req, data,
        output gnt, owner, busy, send, pdOut
    );

endinterface

// File: rtl/serial_tx_sched_arbiter.sv
// Combinational winner pick for serial_tx_sched: round-robin from pointer+1, or lowest index
// when SERIAL_TX_SCHED_FIXED_PRIO_EN is defined (the pointer input then disappears).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
`ifndef SERIAL_TX_SCHED_FIXED_PRIO_EN
    input  logic [IW-1:0]   i_ptr,
`endif
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx
);

`ifdef SERIAL_TX_SCHED_FIXED_PRIO_EN
    always_comb begin
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[k]) begin
                w_found    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IW'(k);
            end
        end
    end
`else
    // Visit candidates ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        logic          w_found;
        logic [IW-1:0] w_cand;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end
`endif

endmodule

// File: rtl/serial_tx_sched.sv
// Shares one SerialTx among NREQ requesters, spacing frames so Send never interrupts a shifting frame.
// Optional macro SERIAL_TX_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module serial_tx_sched
    import serial_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int DW           = DEF_DW,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serial_tx_sched_if.slave   io_bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic [DW-1:0]   w_data;

    sched_state_t    r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_send;
    logic [NREQ-1:0] r_gnt;
    logic [DW-1:0]   r_pdOut;
    logic [IW-1:0]   r_owner;
    logic            r_busy;
`ifndef SERIAL_TX_SCHED_FIXED_PRIO_EN
    logic [IW-1:0]   r_ptr;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req   (io_bus.req),
`ifndef SERIAL_TX_SCHED_FIXED_PRIO_EN
        .i_ptr   (r_ptr),
`endif
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_data = io_bus.data[i*DW +: DW];
            end
        end
    end

    // FLUSH covers a frame possibly cut short by reset, since the transmitter itself is never reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_FLUSH;
            r_cnt   <= CW'(FRAME_CYCLES - 1);
            r_send  <= 1'b0;
            r_gnt   <= '0;
            r_pdOut <= '0;
            r_owner <= '0;
            r_busy  <= 1'b1;
`ifndef SERIAL_TX_SCHED_FIXED_PRIO_EN
            r_ptr   <= IW'(NREQ - 1);
`endif
        end else begin
            r_send <= 1'b0;
            r_gnt  <= '0;
            case (r_state)
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (|io_bus.req) begin
                        r_state <= ST_SEND;
                        r_send  <= 1'b1;
                        r_gnt   <= w_grant;
                        r_pdOut <= w_data;
                        r_owner <= w_idx;
                        r_busy  <= 1'b1;
`ifndef SERIAL_TX_SCHED_FIXED_PRIO_EN
                        r_ptr   <= w_idx;
`endif
                    end
                end
                ST_SEND: begin
                    if (FRAME_CYCLES > 1) begin
                        r_state <= ST_FRAME;
                        r_cnt   <= CW'(FRAME_CYCLES - 2);
                    end else if (GAP_CYCLES > 0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= CW'(GAP_CYCLES - 1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FRAME: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (GAP_CYCLES > 0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= CW'(GAP_CYCLES - 1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_FLUSH;
                    r_cnt   <= CW'(FRAME_CYCLES - 1);
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign io_bus.send  = r_send;
    assign io_bus.gnt   = r_gnt;
    assign io_bus.pdOut = r_pdOut;
    assign io_bus.owner = r_owner;
    assign io_bus.busy  = r_busy;

endmodule

// File: doc/serial_tx_sched.md
# serial_tx_sched

Scheduler that shares one `SerialTx` byte transmitter among several parallel requesters. It accepts byte requests, arbitrates them, and drives the transmitter's `Send`/`PDin` inputs. It spaces frames so that a new `Send` is never issued while the previous frame is still shifting out on `SCout`/`SDout`. It sits between requester logic and the `SerialTx` instance inside the serial link top level.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8
- `DW`, 8: byte width, must match the transmitter's `PDin`
- `FRAME_CYCLES`, 20: Clk cycles from the `Send` cycle until the transmitter is idle again, ≥1
- `GAP_CYCLES`, 2: idle cycles inserted between frames, ≥0
- `Clk`  in  1  single clock, rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Req`  in  NREQ  per-requester request level
- `Data`  in  NREQ*DW  requester i byte at `[i*DW +: DW]`
- `Gnt`  out  NREQ  one-hot, one-cycle acknowledge that the byte was taken
- `Owner`  out  clog2(NREQ)  index of the last granted requester
- `Busy`  out  1  high whenever no new request can be accepted
- `Send`  out  1  one-cycle start pulse to `SerialTx`
- `PDout`  out  DW  byte to `SerialTx` `PDin`, held stable for the whole frame

## Operation
- Reset values, taking effect at the first edge with `Rst`=1: `Send`=0, `Gnt`=0, `PDout`=0, `Owner`=0, `Busy`=1, state=FLUSH, RR pointer=NREQ-1.
- States: FLUSH, IDLE, SEND, FRAME, GAP.
- FLUSH:
  - Counts FRAME_CYCLES cycles, then goes to IDLE.
  - Purpose: lets any frame cut short by reset drain, because the transmitter itself has no reset.
- IDLE:
  - `Busy`=0.
  - If any `Req` is high, select a winner and go to SEND. Otherwise stay.
- SEND, exactly one cycle:
  - `Send`=1, `Gnt[w]`=1, `PDout`=`Data[w]` (registered on entry), `Owner`=w.
  - Next state is FRAME.
- FRAME: lasts FRAME_CYCLES-1 cycles. `PDout` is held.
- GAP: lasts GAP_CYCLES cycles and is skipped when GAP_CYCLES=0. Then go to IDLE.
- `Busy`=1 in every state except IDLE.
- Arbitration:
  - Round-robin search starting at pointer+1, wrapping modulo NREQ.
  - The pointer updates to w on grant.
  - After reset, requester 0 has highest priority.
- Requester contract:
  - Hold `Req` and `Data` until `Gnt`. Dropping `Req` before `Gnt` withdraws the request without side effects.
  - A `Req` still high when IDLE is re-entered counts as a new request.
  - `Data` is sampled only on the IDLE→SEND edge.
- Counter: a single down-counter of width clog2(FRAME_CYCLES+GAP_CYCLES+1), reloaded on each state entry.
- A `Rst` assertion in any state, including SEND and FRAME, takes priority over all transitions.

## Timing
- A `Req` seen in IDLE at edge t produces `Send`/`Gnt` high during cycle t+1. Latency is 1 cycle.
- Frame period: Send-to-Send minimum is FRAME_CYCLES+GAP_CYCLES+1 cycles (23 with defaults).
- `PDout` is stable from the `Send` cycle through the last FRAME cycle.
- After `Rst` deasserts, IDLE is reached after FRAME_CYCLES cycles. The earliest `Send` comes one cycle later.
- Simultaneous requests: exactly one `Gnt` per frame. All other requests wait, and none is lost.

## Configuration
- `SERIAL_TX_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. The RR pointer logic is removed.
  - Undefined (default): round-robin as described above.
  - All timing is identical in both modes.

## Structure
- Shared `serial_pkg` contains:
  - The state enum (FLUSH, IDLE, SEND, FRAME, GAP).
  - Default constants for DW, FRAME_CYCLES and GAP_CYCLES, shared with the `SerialTx`/`SerialRx` wrappers.
- One sub-module, `rr_arbiter`:
  - Combinational pick from `Req` and the pointer, producing a one-hot result plus an index.
  - Carries the fixed-priority variant under the macro.

## Test plan
- Reset: hold `Rst` for 3 cycles with `Req`=4'b1111.
  - During reset: `Send`=0, `Busy`=1.
  - After release: `Send` stays 0 for 20 cycles, then `Gnt`=4'b0001 with `PDout`=`Data[0]`.
- Single request: `Req[2]`=1 with `Data[2]`=8'hA5 in IDLE.
  - Next cycle: `Send`=1, `Gnt`=4'b0100, `Owner`=2.
  - `PDout`=8'hA5 for 20 cycles. `Busy` drops 22 cycles after `Send`.
- Round-robin: all `Req` held high.
  - Grant order 0,1,2,3,0.
  - Sends exactly 23 cycles apart.
- Withdraw: `Req[1]` pulses for one cycle during FRAME. No `Gnt[1]` occurs and the next frame does not start.
- Mid-frame reset: assert `Rst` 5 cycles after `Send` while `Req[3]`=1.
  - `Send`=0 and `Busy`=1 for 20 cycles.
  - Then `Gnt`=4'b1000, since the pointer was reset and requester 3 is the only one asking.
- Fixed priority, with the macro defined: `Req`=4'b1010 held.
  - Every grant is to requester 1.
  - Requester 3 is never granted.
